// File: rtl/tmds_channel_decoder_pkg.sv
// Shared constants and types for the TMDS receive-side channel decoder:
// control tokens, lock FSM states and default timing parameters.
package tmds_channel_decoder_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_CTRL_RUN       = 16;
  localparam int DEF_SEARCH_TIMEOUT = 4096;
  localparam int DEF_LOCK_TIMEOUT   = 4096;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS 10b->8b decode of one aligned symbol, including the four
// control tokens. Shared by all three channel decoders.
module tmds_word_decode
  import tmds_channel_decoder_pkg::*;
(
  input  logic [9:0] q,
  output logic       is_ctrl,
  output logic [1:0] c,
  output logic [7:0] data
);

  logic [7:0] t;

  always_comb begin
    is_ctrl = 1'b1;
    c       = 2'b00;
    case (q)
      TMDS_CTRL_00: c = 2'b00;
      TMDS_CTRL_01: c = 2'b01;
      TMDS_CTRL_10: c = 2'b10;
      TMDS_CTRL_11: c = 2'b11;
      default:      is_ctrl = 1'b0;
    endcase
  end

  // q[9] undoes the optional inversion, q[8] selects XOR vs XNOR chaining.
  always_comb begin
    t       = q[9] ? ~q[7:0] : q[7:0];
    data    = 8'h00;
    data[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: bit-offset search using control-token runs,
// two-stage align/decode pipeline, and lock supervision.
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int CTRL_RUN       = DEF_CTRL_RUN,
  parameter int SEARCH_TIMEOUT = DEF_SEARCH_TIMEOUT,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int TMAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW   = $clog2(TMAX);
  localparam int RW   = $clog2(CTRL_RUN + 1);

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic [RW-1:0]   run_cnt, run_next;
  logic [3:0]      offset_next;
  logic [9:0]      prev;
  logic [9:0]      aligned, aligned_next;
  logic [18:0]     window;
  logic            s1_is_ctrl;
  logic [1:0]      s1_c;
  logic [7:0]      s1_data;
  logic            count_en;
  logic            run_complete;

  // Offsets stop at 9, so the top bit of the 20-bit window is never selected.
  assign window = {tmds_word[8:0], prev};

  always_comb begin
    aligned_next = window[9:0];
    for (int i = 0; i < 10; i++) begin
      if (offset == 4'(i)) aligned_next = window[i +: 10];
    end
  end

  tmds_word_decode u_decode (
    .q       (aligned),
    .is_ctrl (s1_is_ctrl),
    .c       (s1_c),
    .data    (s1_data)
  );

  assign locked       = (state == ST_LOCKED);
  assign count_en     = (state != ST_SLIP);
  assign run_complete = count_en && s1_is_ctrl && (run_cnt >= RW'(CTRL_RUN - 1));

  always_comb begin
    run_next = run_cnt;
    if (count_en) begin
      if (!s1_is_ctrl)                   run_next = '0;
      else if (run_cnt != RW'(CTRL_RUN)) run_next = run_cnt + RW'(1);
    end

    state_next  = state;
    timer_next  = timer;
    offset_next = offset;
    case (state)
      ST_SEARCH: begin
        if (run_complete) begin
          state_next = ST_LOCKED;
          timer_next = '0;
        end else if (timer == TW'(SEARCH_TIMEOUT - 1)) begin
          offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          timer_next  = '0;
          run_next    = '0;
          state_next  = ST_SLIP;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      // Timer doubles as the two-cycle flush counter for the old-offset word.
      ST_SLIP: begin
        if (timer == TW'(1)) begin
          state_next = ST_SEARCH;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      ST_LOCKED: begin
        if (run_complete) begin
          timer_next = '0;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          state_next = ST_SEARCH;
          timer_next = '0;
          run_next   = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: begin
        state_next = ST_SEARCH;
        timer_next = '0;
        run_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SEARCH;
      timer   <= '0;
      run_cnt <= '0;
      offset  <= 4'd0;
      prev    <= 10'd0;
      aligned <= 10'd0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      run_cnt <= run_next;
      offset  <= offset_next;
      prev    <= tmds_word;
      aligned <= aligned_next;
    end
  end

  // c is deliberately not updated on data words so it keeps the last token.
  always_ff @(posedge clk) begin
    if (rst || !locked) begin
      data <= 8'h00;
      c    <= 2'b00;
      de   <= 1'b0;
    end else if (s1_is_ctrl) begin
      data <= 8'h00;
      c    <= s1_c;
      de   <= 1'b0;
    end else begin
      data <= s1_data;
      de   <= 1'b1;
    end
  end

endmodule
